ram_1r1w_init: RTL and testbench
================================

RAM_1R1W_INIT -- requirements
Module: ram_1r1w_init

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, meaning the address width in bits (2^DEPTH entries).
REQ-002 SHALL provide parameter WIDTH, default 32, meaning the data width in bits.
REQ-003 SHALL provide parameter READ_LATENCY, default 2, meaning cycles from an accepted read to dout_valid; only 1 and 2 are legal.
REQ-004 SHALL provide parameter BYPASS, default 1, meaning 1 = read-after-write forwarding enabled, 0 = old data on a same-address collision.
REQ-005 SHALL provide parameter INCLUDE_PARITY, default 0, meaning 1 = store and check parity.
REQ-006 SHALL provide parameter BITS_PER_PARITY, default 32, meaning data bits covered by each even-parity bit (last chunk may be partial).
REQ-007 SHALL provide parameter INIT_VALUE, default 0, meaning the WIDTH-bit word written to every entry during initialisation.
REQ-008 SHALL provide port clk, input, 1 bit: the single clock.
REQ-009 SHALL provide port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-010 SHALL provide port we, input, 1 bit: write enable.
REQ-011 SHALL provide port waddr, input, DEPTH bits: write address.
REQ-012 SHALL provide port din, input, WIDTH bits: write data.
REQ-013 SHALL provide port inj_perr, input, 1 bit: when high with an accepted write, invert parity bit 0 of that write (test only).
REQ-014 SHALL provide port re, input, 1 bit: read enable.
REQ-015 SHALL provide port raddr, input, DEPTH bits: read address.
REQ-016 SHALL provide port dout, output, WIDTH bits: read data.
REQ-017 SHALL provide port dout_valid, output, 1 bit: dout is valid this cycle.
REQ-018 SHALL provide port perr, output, 1 bit: parity mismatch on the current dout, qualified by dout_valid.
REQ-019 SHALL provide port perr_addr, output, DEPTH bits: address of the first parity error since reset.
REQ-020 SHALL provide port perr_seen, output, 1 bit: sticky flag, perr_addr is valid.
REQ-021 SHALL provide port init_done, output, 1 bit: initialisation is complete and the user ports are live.

Function
REQ-022 SHALL implement state machine INIT -> READY; it SHALL enter INIT on reset and leave it only via reset.
REQ-023 In INIT the block SHALL write INIT_VALUE, with correct parity, to address 0, 1, ... 2^DEPTH-1, one per cycle, then move to READY; INIT lasts exactly 2^DEPTH cycles after rst_n deasserts.
REQ-024 In INIT the block SHALL ignore we, re and inj_perr, and SHALL hold init_done=0 and dout_valid=0.
REQ-025 In READY the block SHALL hold init_done=1; each we=1 cycle SHALL write din to waddr, and each re=1 cycle SHALL be an accepted read.
REQ-026 The block SHALL assert dout_valid exactly READ_LATENCY cycles after each accepted read; back-to-back reads give one result per cycle, in order.
REQ-027 With BYPASS=1, a read SHALL return data reflecting every write accepted in the same cycle or earlier, including a same-cycle same-address write.
REQ-028 With BYPASS=0, a same-cycle same-address read SHALL return the pre-write data, and later reads SHALL return the new data.
REQ-029 A forwarded read SHALL return the forwarded word's stored parity, so an inj_perr write is still flagged.
REQ-030 The block SHALL assert perr with dout_valid when the recomputed parity of dout differs from the stored parity; it SHALL hold perr=0 when INCLUDE_PARITY=0.
REQ-031 On the first perr after reset, the block SHALL latch the read address into perr_addr and set perr_seen; later errors SHALL NOT change perr_addr.
REQ-032 The block SHALL accept simultaneous we and re to different addresses without interaction.
REQ-033 Addresses SHALL wrap modulo 2^DEPTH; no illegal-address state exists.

Reset
REQ-034 Asserting rst_n low at any time, including mid-INIT or mid-read, SHALL immediately force dout_valid=0, perr=0, perr_seen=0, perr_addr=0, init_done=0, dout=0 and drop all in-flight reads.
REQ-035 On rst_n deassertion the block SHALL restart INIT from address 0; RAM contents SHALL NOT be asynchronously reset.

Verification
REQ-036 Scenario: DEPTH=4; release reset, read all 16 addresses -> init_done rises 16 cycles after release; every read returns INIT_VALUE with perr=0.
REQ-037 Scenario: READ_LATENCY=2; write 0xA5A5A5A5 to address 3, then read address 3 -> dout=0xA5A5A5A5 with dout_valid exactly 2 cycles after re.
REQ-038 Scenario: BYPASS=1; write 0x12345678 and read address 7 in the same cycle -> returns 0x12345678; with BYPASS=0 -> returns INIT_VALUE.
REQ-039 Scenario: INCLUDE_PARITY=1; write address 5 with inj_perr=1, read address 5, then read address 9 with a second injected error -> perr=1 on both reads; perr_addr=5 and perr_seen=1.
REQ-040 Scenario: assert rst_n low at INIT address 8, release -> INIT restarts and init_done rises 16 cycles after the release.
REQ-041 Scenario: 16 back-to-back reads interleaved with writes -> one dout_valid per read, in order, with data consistent with REQ-027/REQ-028.

Source files
------------

// File: rtl/ram_1r1w_init.sv
// 1R1W RAM that fills itself with INIT_VALUE after reset, with optional write-to-read
// forwarding, per-chunk even parity and a 1- or 2-cycle read pipeline.
module ram_1r1w_init #(
    parameter int               DEPTH           = 4,
    parameter int               WIDTH           = 32,
    parameter int               READ_LATENCY    = 2,
    parameter int               BYPASS          = 1,
    parameter int               INCLUDE_PARITY  = 0,
    parameter int               BITS_PER_PARITY = 32,
    parameter logic [WIDTH-1:0] INIT_VALUE      = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0] din,
    input  logic             inj_perr,
    input  logic             re,
    input  logic [DEPTH-1:0] raddr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             perr,
    output logic [DEPTH-1:0] perr_addr,
    output logic             perr_seen,
    output logic             init_done
);
    localparam int ENTRIES = 1 << DEPTH;
    localparam int NPAR    = (WIDTH + BITS_PER_PARITY - 1) / BITS_PER_PARITY;
    localparam int LAST    = READ_LATENCY - 1;

    typedef enum logic {ST_INIT, ST_READY} state_t;
    typedef struct packed {
        logic [NPAR-1:0]  par;
        logic [WIDTH-1:0] data;
    } word_t;

    function automatic logic [NPAR-1:0] calc_par(input logic [WIDTH-1:0] d);
        logic [NPAR-1:0] p;
        p = '0;
        for (int b = 0; b < WIDTH; b++) p[b / BITS_PER_PARITY] ^= d[b];
        return p;
    endfunction

    state_t           state_q, state_d;
    logic [DEPTH-1:0] init_addr_q, init_addr_d;
    word_t            mem_q [ENTRIES];
    logic             mem_we;
    logic [DEPTH-1:0] mem_wa;
    word_t            mem_wd, wr_word, rd_word;
    logic             ready, rd_acc;

    word_t                     pipe_q [READ_LATENCY];
    word_t                     pipe_d [READ_LATENCY];
    logic [DEPTH-1:0]          paddr_q [READ_LATENCY];
    logic [DEPTH-1:0]          paddr_d [READ_LATENCY];
    logic [READ_LATENCY-1:0]   vld_pipe_q, vld_pipe_d;
    logic                      perr_seen_q, perr_seen_d;
    logic [DEPTH-1:0]          perr_addr_q, perr_addr_d;

    assign ready  = (state_q == ST_READY);
    assign rd_acc = ready & re;

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == ST_INIT) begin
            init_addr_d = init_addr_q + DEPTH'(1);
            if (&init_addr_q) state_d = ST_READY;
        end
    end

    // Init sweep owns the write port until READY; user writes are dropped meanwhile.
    always_comb begin
        wr_word.data = din;
        wr_word.par  = calc_par(din) ^ NPAR'(inj_perr);
        mem_we       = rst_n & (ready ? we : 1'b1);
        mem_wa       = ready ? waddr : init_addr_q;
        mem_wd       = ready ? wr_word : word_t'{par: calc_par(INIT_VALUE), data: INIT_VALUE};
        rd_word      = mem_q[raddr];
        if (BYPASS != 0 && we && waddr == raddr) rd_word = wr_word;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    always_comb begin
        vld_pipe_d[0] = rd_acc;
        pipe_d[0]     = rd_acc ? rd_word : pipe_q[0];
        paddr_d[0]    = rd_acc ? raddr : paddr_q[0];
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            pipe_d[i]     = vld_pipe_q[i-1] ? pipe_q[i-1] : pipe_q[i];
            paddr_d[i]    = vld_pipe_q[i-1] ? paddr_q[i-1] : paddr_q[i];
        end
    end

    assign dout       = pipe_q[LAST].data;
    assign dout_valid = vld_pipe_q[LAST];
    assign perr       = (INCLUDE_PARITY != 0) && dout_valid &&
                        (calc_par(pipe_q[LAST].data) != pipe_q[LAST].par);

    // Only the first error's address is kept.
    always_comb begin
        perr_seen_d = perr_seen_q | perr;
        perr_addr_d = (perr && !perr_seen_q) ? paddr_q[LAST] : perr_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            vld_pipe_q  <= '0;
            perr_seen_q <= 1'b0;
            perr_addr_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i]  <= '0;
                paddr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            vld_pipe_q  <= vld_pipe_d;
            perr_seen_q <= perr_seen_d;
            perr_addr_q <= perr_addr_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i]  <= pipe_d[i];
                paddr_q[i] <= paddr_d[i];
            end
        end
    end

    assign perr_seen = perr_seen_q;
    assign perr_addr = perr_addr_q;
    assign init_done = ready;
endmodule

// File: tb/tb_ram_1r1w_init.sv
// Directed bench: two instances share stimulus, u0 (latency 2, bypass, byte parity)
// and u1 (latency 1, no bypass, no parity), each with its own INIT_VALUE.
module tb_ram_1r1w_init;
    localparam logic [31:0] INIT0 = 32'hC0DE0001;
    localparam logic [31:0] INIT1 = 32'h5A5A0000;

    logic        clk, rst_n, we, inj_perr, re;
    logic [3:0]  waddr, raddr;
    logic [31:0] din;
    logic [31:0] dout0, dout1;
    logic        dv0, dv1, perr0, perr1, ps0, ps1, id0, id1;
    logic [3:0]  pa0, pa1;

    int          total, bad;
    logic        pend_v, pend_p;
    logic [31:0] pend_d;

    ram_1r1w_init #(.DEPTH(4), .WIDTH(32), .READ_LATENCY(2), .BYPASS(1), .INCLUDE_PARITY(1),
                    .BITS_PER_PARITY(8), .INIT_VALUE(INIT0)) u0 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .din(din), .inj_perr(inj_perr),
        .re(re), .raddr(raddr), .dout(dout0), .dout_valid(dv0), .perr(perr0),
        .perr_addr(pa0), .perr_seen(ps0), .init_done(id0));

    ram_1r1w_init #(.DEPTH(4), .WIDTH(32), .READ_LATENCY(1), .BYPASS(0), .INCLUDE_PARITY(0),
                    .BITS_PER_PARITY(32), .INIT_VALUE(INIT1)) u1 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .din(din), .inj_perr(inj_perr),
        .re(re), .raddr(raddr), .dout(dout1), .dout_valid(dv1), .perr(perr1),
        .perr_addr(pa1), .perr_seen(ps1), .init_done(id1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; u1 results land this cycle, u0 results one cycle later.
    task automatic cyc(input logic w, input logic [3:0] wa, input logic [31:0] wd, input logic inj,
                       input logic r, input logic [3:0] ra, input logic [31:0] e0,
                       input logic p0, input logic [31:0] e1);
        we = w; waddr = wa; din = wd; inj_perr = inj; re = r; raddr = ra;
        @(negedge clk);
        check("u1_vld", dv1, r);
        if (r) begin
            check("u1_dout", dout1, e1);
            check("u1_perr", perr1, 0);
        end
        check("u0_vld", dv0, pend_v);
        if (pend_v) begin
            check("u0_dout", dout0, pend_d);
            check("u0_perr", perr0, pend_p);
        end
        pend_v = r; pend_d = e0; pend_p = p0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic init_wait();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("u0_init_done", id0, k == 16);
            check("u1_init_done", id1, k == 16);
            check("u0_init_vld", dv0, 0);
            check("u1_init_vld", dv1, 0);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        clk = 0; rst_n = 0;
        we = 0; waddr = 0; din = 0; inj_perr = 0; re = 0; raddr = 0;
        pend_v = 0; pend_p = 0; pend_d = 0;

        repeat (2) @(negedge clk);
        check("rst_init_done", id0, 0);
        check("rst_vld", dv0, 0);
        check("rst_dout", dout0, 0);
        check("rst_perr_seen", ps0, 0);
        check("rst_perr_addr", pa0, 0);

        // User traffic during INIT must be ignored, including this write to addr 2.
        we = 1; waddr = 4'd2; din = 32'hFFFFFFFF; inj_perr = 1; re = 1; raddr = 0;
        rst_n = 1;
        init_wait();

        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1, 4'(i), INIT0, 0, INIT1);
        idle();

        cyc(1, 4'd3, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 4'd3, 32'hA5A5A5A5, 0, 32'hA5A5A5A5);
        idle();

        // Same-cycle same-address: u0 forwards, u1 returns old data.
        cyc(1, 4'd7, 32'h12345678, 0, 1, 4'd7, 32'h12345678, 0, INIT1);
        cyc(0, 0, 0, 0, 1, 4'd7, 32'h12345678, 0, 32'h12345678);
        cyc(1, 4'd11, 32'hBEEF0011, 0, 1, 4'd3, 32'hA5A5A5A5, 0, 32'hA5A5A5A5);
        idle();
        check("perr_seen_pre", ps0, 0);

        cyc(1, 4'd5, 32'h00000000, 1, 0, 0, 0, 0, 0);
        cyc(1, 4'd9, 32'hFFFF0000, 1, 1, 4'd5, 32'h00000000, 1, 32'h00000000);
        cyc(1, 4'd10, 32'h00000001, 1, 1, 4'd9, 32'hFFFF0000, 1, 32'hFFFF0000);
        cyc(0, 0, 0, 0, 1, 4'd10, 32'h00000001, 1, 32'h00000001);
        cyc(1, 4'd12, 32'h00000003, 1, 1, 4'd12, 32'h00000003, 1, INIT1);
        idle();
        idle();
        check("u0_perr_seen", ps0, 1);
        check("u0_perr_addr", pa0, 4'd5);
        check("u1_perr_seen", ps1, 0);

        for (int i = 0; i < 16; i++)
            cyc(1, 4'(i + 1), 32'h1000 + i, 0, 1, 4'(i),
                (i == 0) ? INIT0 : 32'h1000 + i - 1, 0,
                (i == 0) ? INIT1 : 32'h1000 + i - 1);
        idle();
        cyc(0, 0, 0, 0, 1, 4'd0, 32'h100F, 0, 32'h100F);
        idle();
        idle();
        check("u0_perr_addr_kept", pa0, 4'd5);

        // Reset with a u0 read still in flight.
        cyc(0, 0, 0, 0, 1, 4'd3, 32'h1002, 0, 32'h1002);
        re = 0;
        #2 rst_n = 0;
        #1;
        check("arst_vld", dv0, 0);
        check("arst_dout", dout0, 0);
        check("arst_perr_seen", ps0, 0);
        check("arst_perr_addr", pa0, 0);
        check("arst_init_done", id0, 0);
        pend_v = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (8) @(negedge clk);
        check("mid_init_done", id0, 0);
        #2 rst_n = 0;
        #1;
        check("mid_rst_init_done", id0, 0);
        @(negedge clk);
        rst_n = 1;
        init_wait();

        cyc(0, 0, 0, 0, 1, 4'd5, INIT0, 0, INIT1);
        cyc(0, 0, 0, 0, 1, 4'd12, INIT0, 0, INIT1);
        idle();
        check("post_perr_seen", ps0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
